cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
Common data bus arbiter for the out-of-order core. It takes completed results from the functional units (alu, brAlu, mul, div, mem) and grants one per cycle using round-robin priority. The granted unit receives a same-cycle read acknowledge, and its result is broadcast one cycle later as a registered CDB beat. Reservation stations, the ROB and the register file all snoop that broadcast.

Parameters:
NUM_FU, 5, number of requesting functional units (2..8); index 0=alu, 1=brAlu, 2=mul, 3=div, 4=mem.
DATA_WIDTH, 32, result width.
ROB_IDX_WIDTH, 3, ROB tag width.
SRC_WIDTH, $clog2(NUM_FU), width of the source id (minimum 1).

Ports:
clk_in  input  1  system clock; one clock domain.
rst_in  input  1  reset, synchronous, active-high.
fu_valid_in  input  NUM_FU  bit i high = FU i holds a result.
fu_data_in  input  NUM_FU*DATA_WIDTH  packed results; FU i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
fu_rob_idx_in  input  NUM_FU*ROB_IDX_WIDTH  packed ROB tags, same packing as fu_data_in.
cdb_ready_in  input  1  high = downstream can accept a broadcast next cycle.
flush_in  input  1  mispredict flush; kills grants and the broadcast.
fu_read_out  output  NUM_FU  one-hot grant/acknowledge, combinational.
cdb_valid_out  output  1  broadcast valid.
cdb_data_out  output  DATA_WIDTH  broadcast result.
cdb_rob_idx_out  output  ROB_IDX_WIDTH  broadcast ROB tag.
cdb_src_out  output  SRC_WIDTH  index of the granting FU.

Behaviour:
- State: rr_ptr (SRC_WIDTH, the highest-priority index) and the output registers valid_q, data_q, rob_q, src_q.
- Reset (sync, rst_in high at a clock edge): rr_ptr=0, valid_q=0, data_q=0, rob_q=0, src_q=0.
  - fu_read_out=0 combinationally while rst_in is high.
  - Reset overrides flush and any grant in the same cycle.
- Grant (combinational):
  - Enabled when cdb_ready_in=1, flush_in=0 and rst_in=0.
  - Scan indices rr_ptr, rr_ptr+1, ... modulo NUM_FU; grant the first i with fu_valid_in[i]=1.
  - fu_read_out = one-hot(i). At most one bit is ever set. All zero when nothing is granted.
- Handshake:
  - The FU must hold valid, data and tag stable until it sees fu_read_out[i]=1 at a clock edge.
  - At that edge the result is consumed; the FU may drop valid or present a new result next cycle.
  - fu_read_out never depends on cdb_valid_out, so there is no combinational loop with the FUs.
- On a clock edge with a grant to i:
  - valid_q<=1; data_q<=fu_data_in[i]; rob_q<=fu_rob_idx_in[i]; src_q<=i.
  - rr_ptr<=(i+1) mod NUM_FU, wrapping NUM_FU-1 to 0.
- On a clock edge with no grant:
  - valid_q<=0; data_q, rob_q and src_q hold; rr_ptr holds.
- Outputs:
  - cdb_valid_out = valid_q & ~flush_in.
  - cdb_data_out=data_q, cdb_rob_idx_out=rob_q, cdb_src_out=src_q.
- Latency and throughput:
  - Grant to broadcast is exactly 1 cycle.
  - Each grant produces exactly one single-cycle broadcast.
  - Back-to-back grants give continuous broadcasts at 1 result/cycle.
- cdb_ready_in=0: no grant; pending FUs keep waiting. The already-registered beat still appears this cycle, and valid drops after the edge.
- flush_in=1:
  - No grant that cycle; the current broadcast is masked.
  - valid_q<=0 at the edge; rr_ptr holds.
  - FUs handle their own flush; the arbiter does not clear anything in the FUs.
- Fairness: a continuously requesting FU is granted within NUM_FU cycles while cdb_ready_in=1 and flush_in=0.

Test Plan:
- Reset: hold rst_in 2 cycles with fu_valid_in=5'b11111 -> fu_read_out=0, cdb_valid_out=0, all outputs 0; after release the first grant is to index 0.
- Single requester: fu_valid_in=5'b00100, data 0x0000_00AB, tag 5 -> fu_read_out=5'b00100 the same cycle; next cycle cdb_valid_out=1, data 0xAB, rob 5, src 2; the cycle after, valid=0.
- All five request continuously for 7 cycles -> grant order 0,1,2,3,4,0,1; one broadcast per cycle with matching src; the rr_ptr 4->0 wrap is checked.
- cdb_ready_in=0 for 3 cycles with 5'b00011 pending -> fu_read_out=0 throughout, no broadcasts; on release, grants go 0 then 1.
- Flush: grant FU1 in cycle N, assert flush_in in N+1 with FU3 valid -> cdb_valid_out=0 in N+1, FU3 not read; FU3 is granted in N+2 and broadcast in N+3.
- Reset mid-stream: rst_in asserted during a back-to-back stream -> next cycle valid=0 and rr_ptr=0; the next grant after release goes to the lowest valid index.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common data bus arbiter with a registered one-beat broadcast
module cdb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_IDX_WIDTH = 3,
  parameter int SRC_WIDTH = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_FU-1:0]               fu_valid_in,
  input  logic [NUM_FU*DATA_WIDTH-1:0]    fu_data_in,
  input  logic [NUM_FU*ROB_IDX_WIDTH-1:0] fu_rob_idx_in,
  input  logic                            cdb_ready_in,
  input  logic                            flush_in,
  output logic [NUM_FU-1:0]               fu_read_out,
  output logic                            cdb_valid_out,
  output logic [DATA_WIDTH-1:0]           cdb_data_out,
  output logic [ROB_IDX_WIDTH-1:0]        cdb_rob_idx_out,
  output logic [SRC_WIDTH-1:0]            cdb_src_out
);
  logic [SRC_WIDTH-1:0] rr_ptr, sel, src_q;
  logic [DATA_WIDTH-1:0] data_a [NUM_FU];
  logic [ROB_IDX_WIDTH-1:0] rob_a [NUM_FU];
  logic [DATA_WIDTH-1:0] data_q;
  logic [ROB_IDX_WIDTH-1:0] rob_q;
  logic hit, gnt, valid_q;
  for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
    assign data_a[g] = fu_data_in[g*DATA_WIDTH +: DATA_WIDTH];
    assign rob_a[g] = fu_rob_idx_in[g*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
  end
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_FU-1; i >= 0; i--)
      if (fu_valid_in[i] && SRC_WIDTH'(i) < rr_ptr) begin
        hit = 1'b1;
        sel = SRC_WIDTH'(i);
      end
    for (int i = NUM_FU-1; i >= 0; i--)
      if (fu_valid_in[i] && SRC_WIDTH'(i) >= rr_ptr) begin
        hit = 1'b1;
        sel = SRC_WIDTH'(i);
      end
  end
  assign gnt = hit & cdb_ready_in & ~flush_in & ~rst_in;
  assign fu_read_out = gnt ? NUM_FU'(1) << sel : '0;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      rob_q <= '0;
      src_q <= '0;
    end else begin
      valid_q <= gnt;
      if (gnt) begin
        data_q <= data_a[sel];
        rob_q <= rob_a[sel];
        src_q <= sel;
        rr_ptr <= (sel == SRC_WIDTH'(NUM_FU-1)) ? '0 : sel + 1'b1;
      end
    end
  end
  assign cdb_valid_out = valid_q & ~flush_in;
  assign cdb_data_out = data_q;
  assign cdb_rob_idx_out = rob_q;
  assign cdb_src_out = src_q;
endmodule
